seg_display_scan: RTL and testbench
===================================

# seg_display_scan

Time-multiplexed driver for the board's 4-digit 7-segment display. It takes the 16-bit `display` word that the single-cycle CPU top assembles from the `sw` selector and shows it as four hex digits. Each frame it captures one tear-free snapshot of that word, then scans the digits in turn, with a blanking gap between digits to suppress ghosting. It sits directly downstream of the CPU top's display multiplexer and replaces the separate digit-select and hex-decode logic with a single registered block.

## Interface
- `DIV`, default 100000: clock cycles per digit slot (1 ms at 100 MHz). Must be ≥ 2.
- `BLANK`, default 1000: cycles at the start of each slot with all digits off. Must satisfy 1 ≤ BLANK < DIV.
- `system_clk`  in  1  board clock; the only clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `display`  in  16  hex word to show: digit i = display[4i+3:4i]; digit 3 is leftmost.
- `AN`  out  4  digit enables, active-low; AN[i] = 0 selects digit i.
- `dispcode`  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}. dp is always 1 (off).

## Operation
- **Internal state**
  - `cnt`: 0..DIV-1, slot cycle counter.
  - `idx`: 0..3, digit index.
  - `frame`: 16-bit snapshot of `display`.
- **Counter update, every edge unless Reset**
  - If cnt == DIV-1: cnt <= 0 and idx <= idx+1 (mod 4, 3 wraps to 0).
  - Otherwise: cnt <= cnt+1.
- **Snapshot:** frame <= display on any edge where cnt == 0 and idx == 0. No other edge changes `frame`. Changes to `display` mid-frame are not visible until the next frame.
- **Phase, from the current cnt**
  - BLANK phase when cnt < BLANK.
  - ON phase otherwise.
- **Registered outputs, every edge**
  - BLANK phase: AN <= 4'b1111, dispcode <= 8'hFF.
  - ON phase: AN <= 4'b1111 with bit idx cleared; dispcode <= hex7(frame[4*idx+3 : 4*idx]).
- **hex7 encodings, active-low:**
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- **Reset (synchronous)**
  - cnt=0, idx=0, frame=16'h0000, AN=4'b1111, dispcode=8'hFF.
  - Reset asserted mid-slot or mid-frame aborts the scan. The next frame starts cleanly from digit 0 with a fresh snapshot on the first edge after Reset deasserts.
- **Enable invariant:** AN never has more than one bit low. It is never low during a BLANK phase, including the cycle at each slot boundary.

## Timing
- Outputs are registered and lag the internal counter by one cycle. Nothing combinational runs from `display` to any output.
- **Frame:** period is 4·DIV cycles. Each slot shows BLANK output cycles of all-off followed by DIV−BLANK cycles of one lit digit. Scan order is digit 0, 1, 2, 3, then back to 0.
- **After Reset deasserts, first edge is E1**
  - E1: snapshot taken; outputs blank.
  - Edges E1..E(BLANK): outputs all-off.
  - From edge E(BLANK+1): digit 0 is lit with the snapshot value.
- **Sampling:** `display` is sampled only at E1 and then every 4·DIV edges after it.

## Test plan
Bench parameters: DIV=8, BLANK=2.
1. **Reset.** Hold Reset for 3 cycles with display=16'h1234.
   - During reset and on the first two edges after release: AN=1111, dispcode=FF.
   - On the 3rd edge after release: AN=1110, dispcode=99 (digit '4').
2. **Full frame.** display=16'h1234 held constant for 32 cycles after release.
   - Lit digits appear in order AN=1110/99, 1101/B0, 1011/A4, 0111/F9.
   - Each lit digit lasts 6 cycles and is preceded by 2 blank cycles.
   - AN never has two bits low.
3. **All codes.** Step `display` through 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, one per frame. Every decoded value must match the hex7 encodings listed under Operation.
4. **Tear-free capture.** Change display from 16'hAAAA to 16'h5555 while digit 1 is lit.
   - Digits 1–3 of the current frame still show 88.
   - The next frame shows 92 on all four digits.
5. **Mid-frame reset.** Assert Reset for 1 cycle while digit 2 is lit.
   - Outputs go to AN=1111, dispcode=FF on the next edge.
   - Scan restarts at digit 0 with the new snapshot, after exactly 2 blank cycles.

Source files
------------

// File: rtl/seg_display_scan.sv
// seg_display_scan
//
// Time-multiplexed driver for a 4-digit, active-low 7-segment display.
// Once per frame it captures a tear-free snapshot of the 16-bit display word.
// It then scans digits 0..3. Each digit slot starts with a blanking gap that
// suppresses ghosting between neighbouring digits.
//
// Parameters
//   DIV        clock cycles per digit slot (>= 2)
//   BLANK      all-off cycles at the start of each slot (1 <= BLANK < DIV)
//
// Ports
//   system_clk in   1  board clock, rising edge
//   Reset      in   1  synchronous, active-high reset
//   display    in  16  hex word; digit i = display[4i+3:4i], digit 3 leftmost
//   AN         out  4  digit enables, active-low, at most one bit low
//   dispcode   out  8  segments, active-low, {dp,g,f,e,d,c,b,a}; dp always off
//
// All outputs are registered and lag the slot counter by one cycle. No
// combinational path runs from display to any output.

module seg_display_scan #(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned BLANK = 1000
) (
    input  logic        system_clk,
    input  logic        Reset,
    input  logic [15:0] display,
    output logic [3:0]  AN,
    output logic [7:0]  dispcode
);

    localparam int unsigned CntW = $clog2(DIV);
    localparam logic [CntW-1:0] CntLast  = CntW'(DIV - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK);

    // Active-low hex font, {dp,g,f,e,d,c,b,a}.
    function automatic logic [7:0] hex7(input logic [3:0] v);
        logic [7:0] code;
        code = 8'hFF;
        case (v)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            4'hF: code = 8'h8E;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     frame_q, frame_d;
    logic [3:0]      an_q, an_d;
    logic [7:0]      seg_q, seg_d;

    logic            slot_end;
    logic            frame_start;
    logic            blank_phase;
    logic [3:0]      nibble;

    always_comb begin
        slot_end    = (cnt_q == CntLast);
        frame_start = (cnt_q == '0) && (idx_q == 2'd0);
        blank_phase = (cnt_q < CntBlank);
        nibble      = frame_q[{idx_q, 2'b00} +: 4];

        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
        // Single capture point per frame keeps all four digits consistent.
        frame_d = frame_start ? display : frame_q;

        // The slot-boundary cycle always has cnt == 0 < BLANK, so a digit is
        // never enabled while the index is changing.
        an_d  = 4'b1111;
        seg_d = 8'hFF;
        if (!blank_phase) begin
            an_d[idx_q] = 1'b0;
            seg_d       = hex7(nibble);
        end
    end

    always_ff @(posedge system_clk) begin
        if (Reset) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            frame_q <= 16'h0000;
            an_q    <= 4'b1111;
            seg_q   <= 8'hFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign AN       = an_q;
    assign dispcode = seg_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with DIV=8, BLANK=2.
// Outputs are sampled on the falling clock edge; inputs change there too.

module tb_seg_display_scan;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;

    logic        system_clk;
    logic        Reset;
    logic [15:0] display;
    logic [3:0]  AN;
    logic [7:0]  dispcode;

    int n_checks = 0;
    int n_pass   = 0;

    seg_display_scan #(
        .DIV  (DIV),
        .BLANK(BLANK)
    ) u_dut (
        .system_clk(system_clk),
        .Reset     (Reset),
        .display   (display),
        .AN        (AN),
        .dispcode  (dispcode)
    );

    initial begin
        system_clk = 1'b0;
        forever #5 system_clk = ~system_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Walks n_edges output edges of a frame starting at its first edge.
    // codes packs the expected segment codes as {d3,d2,d1,d0}. When change_at
    // is non-negative, display is switched to new_val right after that edge.
    task automatic check_frame(input string tag, input logic [31:0] codes,
                               input int n_edges, input int change_at,
                               input logic [15:0] new_val);
        logic [3:0] an_exp;
        logic [7:0] seg_exp;
        for (int k = 0; k < n_edges; k++) begin
            int d;
            int pos;
            @(negedge system_clk);
            d   = k / int'(DIV);
            pos = k % int'(DIV);
            if (pos < int'(BLANK)) begin
                an_exp  = 4'b1111;
                seg_exp = 8'hFF;
            end else begin
                an_exp    = 4'b1111;
                an_exp[d] = 1'b0;
                seg_exp   = codes[8*d +: 8];
            end
            check($sformatf("%s[%0d]", tag, k), {20'd0, AN, dispcode},
                  {20'd0, an_exp, seg_exp});
            check($sformatf("%s_onehot[%0d]", tag, k), 32'($countones(~AN) <= 1), 32'd1);
            if (k == change_at) display = new_val;
        end
    endtask

    initial begin
        Reset   = 1'b1;
        display = 16'h1234;

        // Held in reset for three edges: all off.
        for (int i = 0; i < 3; i++) begin
            @(negedge system_clk);
            check($sformatf("reset[%0d]", i), {20'd0, AN, dispcode}, {20'd0, 4'b1111, 8'hFF});
        end
        Reset = 1'b0;

        // First frame after release: 2 blanks then digit 0 = '4'.
        check_frame("f1234", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 32, -1, 16'h0);

        // All sixteen codes across four frames.
        display = 16'h0123;
        check_frame("f0123", {8'hC0, 8'hF9, 8'hA4, 8'hB0}, 32, -1, 16'h0);
        display = 16'h4567;
        check_frame("f4567", {8'h99, 8'h92, 8'h82, 8'hF8}, 32, -1, 16'h0);
        display = 16'h89AB;
        check_frame("f89ab", {8'h80, 8'h90, 8'h88, 8'h83}, 32, -1, 16'h0);
        display = 16'hCDEF;
        check_frame("fcdef", {8'hC6, 8'hA1, 8'h86, 8'h8E}, 32, -1, 16'h0);

        // Tear-free: change to 5555 while digit 1 is lit; this frame stays 88.
        display = 16'hAAAA;
        check_frame("ftear", {8'h88, 8'h88, 8'h88, 8'h88}, 32, 11, 16'h5555);
        check_frame("f5555", {8'h92, 8'h92, 8'h92, 8'h92}, 32, -1, 16'h0);

        // Mid-frame reset while digit 2 is lit (edge 19 = slot 2, cycle 3).
        check_frame("fpre", {8'h92, 8'h92, 8'h92, 8'h92}, 20, -1, 16'h0);
        Reset   = 1'b1;
        display = 16'h9876;
        @(negedge system_clk);
        check("midreset", {20'd0, AN, dispcode}, {20'd0, 4'b1111, 8'hFF});
        Reset = 1'b0;
        check_frame("f9876", {8'h90, 8'h80, 8'hF8, 8'h82}, 32, -1, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
